shift_chain_ctrl: RTL and testbench
===================================

SHIFT_CHAIN_CTRL -- requirements
Module: shift_chain_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, bit width of each chain register and of cmd_data.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: cmd_valid  input  1  command offered.
REQ-005 SHALL have port: cmd_ready  output  1  controller idle, command accepted when valid&&ready.
REQ-006 SHALL have port: cmd_op  input  2  operation: 0 LOAD, 1 SHIFT, 2 ROTATE, 3 CLEAR.
REQ-007 SHALL have port: cmd_count  input  3  step count for SHIFT/ROTATE; value 0 encodes 8.
REQ-008 SHALL have port: cmd_data  input  WIDTH  value written into a by LOAD and on every SHIFT step.
REQ-009 SHALL have port: abort  input  1  terminate a running command.
REQ-010 SHALL have ports: a, b, c, d  output  WIDTH each  chain registers, a first, d last.
REQ-011 SHALL have ports: busy  output  1  state is RUN; done  output  1  one-cycle completion pulse; aborted  output  1  qualifies done.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-013 SHALL drive cmd_ready high only in IDLE; busy high only in RUN; done high only in DONE.
REQ-014 SHALL latch op, data and step count on the acceptance edge E0 and enter RUN; inputs are ignored after E0.
REQ-015 SHALL perform exactly one step per RUN cycle at edges E1..En; n = cmd_count for SHIFT/ROTATE with 0 meaning 8, n = 1 for LOAD/CLEAR.
REQ-016 SHALL use the SHIFT step: d<=c, c<=b, b<=a, a<=data, all from pre-edge values, i.e. nonblocking semantics.
REQ-017 SHALL use the ROTATE step: a<=d, b<=a, c<=b, d<=c, all from pre-edge values.
REQ-018 SHALL use LOAD: a<=data, with b, c, d unchanged; CLEAR: a=b=c=d=0.
REQ-019 SHALL enter DONE after En, hold done=1 for one cycle, return to IDLE, and raise cmd_ready in the cycle after done.
REQ-020 SHALL make abort, when sampled high in a RUN cycle, suppress that cycle's step and go to DONE with aborted=1; abort on the same edge as the final step also suppresses that step.
REQ-021 SHALL ignore abort in IDLE and DONE; aborted SHALL be 0 whenever done=0.
REQ-022 SHALL change the chain registers only by the steps above.

Reset
REQ-023 SHALL place, on rst high and regardless of clk, the FSM in IDLE; set a, b, c, d, the step counter and latched command to 0; and set busy=done=aborted=0 and cmd_ready=1.
REQ-024 SHALL make rst asserted mid-RUN discard the command with no done pulse.

Configuration
REQ-025 SHALL define macro SHIFT_CHAIN_STATUS_EN: when defined, adds output op_cnt (16 bits), reset to 0, incremented on each non-aborted done and wrapping 0xFFFF->0.
REQ-026 SHALL, without SHIFT_CHAIN_STATUS_EN, have no op_cnt port and leave all other behaviour identical.

Structure
REQ-027 SHALL place the op encoding enum (LOAD/SHIFT/ROTATE/CLEAR), the FSM state enum and the default WIDTH constant in shared package shift_chain_pkg.
REQ-028 SHALL use one sub-module, shift_chain_regs (four WIDTH registers with step/op select), with the FSM and counter in shift_chain_ctrl.

Verification
REQ-029 SHALL cover: reset mid-RUN -> outputs 0, cmd_ready=1, no done.
REQ-030 SHALL cover: LOAD 5, then SHIFT data=7 count=3 -> after E3 a=7, b=7, c=7, d=5; done one cycle later; total accept-to-ready 5 cycles.
REQ-031 SHALL cover: chain a=1, b=2, c=3, d=4, ROTATE count=0 -> 8 steps, final a=1, b=2, c=3, d=4, busy high exactly 8 cycles.
REQ-032 SHALL cover: ROTATE count=5 with abort high in the 3rd RUN cycle -> exactly 2 steps applied, done=1 with aborted=1.
REQ-033 SHALL cover: CLEAR while cmd_valid is held high -> all registers 0 after E1, next command accepted only after the done cycle.
REQ-034 SHALL cover, with SHIFT_CHAIN_STATUS_EN: 3 completed commands plus 1 aborted -> op_cnt=3.

Source files
------------

// File: rtl/shift_chain_pkg.sv
// shift_chain_pkg
// Shared definitions for the shift-chain controller:
//   - op_e    : command operation encoding (LOAD/SHIFT/ROTATE/CLEAR)
//   - state_e : controller FSM states (IDLE/RUN/DONE)
//   - DEFAULT_WIDTH : default chain register width
//   - step_total()  : number of RUN steps a command takes
package shift_chain_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_SHIFT  = 2'd1,
        OP_ROTATE = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // SHIFT/ROTATE run cmd_count steps, where a count of 0 stands for 8.
    // LOAD/CLEAR always take a single step.
    function automatic logic [3:0] step_total(input op_e op, input logic [2:0] count);
        logic [3:0] n;
        n = 4'd1;
        if (op == OP_SHIFT || op == OP_ROTATE) begin
            n = (count == 3'd0) ? 4'd8 : {1'b0, count};
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_chain_regs.sv
// shift_chain_regs
// Four WIDTH-bit chain registers (a first, d last) updated by one step of the
// selected operation whenever step is high.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (clears all stages)
//   step         : apply one step of op on this edge
//   op           : LOAD / SHIFT / ROTATE / CLEAR
//   data         : value entering stage a for LOAD and SHIFT
//   a, b, c, d   : chain register contents
module shift_chain_regs
    import shift_chain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  op_e              op,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d
);

    logic [WIDTH-1:0] stage_q [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_stage
            logic [WIDTH-1:0] q_reg;
            logic [WIDTH-1:0] feed;

            // Stage a is fed by data (SHIFT) or by d (ROTATE wrap-around);
            // every other stage takes its upstream neighbour.
            if (gi == 0) begin : g_head
                assign feed = (op == OP_ROTATE) ? stage_q[3] : data;
            end else begin : g_body
                assign feed = stage_q[gi-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (step) begin
                    case (op)
                        OP_CLEAR: q_reg <= '0;
                        // LOAD only touches stage a; b..d hold.
                        OP_LOAD:  if (gi == 0) q_reg <= data;
                        default:  q_reg <= feed;
                    endcase
                end
            end

            assign stage_q[gi] = q_reg;
        end
    endgenerate

    assign a = stage_q[0];
    assign b = stage_q[1];
    assign c = stage_q[2];
    assign d = stage_q[3];

endmodule

// File: rtl/shift_chain_ctrl.sv
// shift_chain_ctrl
// Command-driven controller for a four-register shift chain. A command is
// accepted in IDLE (cmd_valid && cmd_ready), executes one step per RUN cycle,
// then spends one cycle in DONE pulsing done before returning to IDLE.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   cmd_valid/ready : command handshake (ready only in IDLE)
//   cmd_op          : 0 LOAD, 1 SHIFT, 2 ROTATE, 3 CLEAR
//   cmd_count       : SHIFT/ROTATE step count, 0 means 8
//   cmd_data        : value fed into a by LOAD and each SHIFT step
//   abort           : end a running command; that cycle's step is dropped
//   a, b, c, d      : chain registers
//   busy            : high in RUN
//   done, aborted   : one-cycle completion pulse, aborted qualifies it
//   op_cnt          : (only with SHIFT_CHAIN_STATUS_EN) count of
//                     non-aborted completions, wraps at 16 bits
// Optional feature macro: SHIFT_CHAIN_STATUS_EN
module shift_chain_ctrl
    import shift_chain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done,
    output logic             aborted
`ifdef SHIFT_CHAIN_STATUS_EN
    ,
    output logic [15:0]      op_cnt
`endif
);

    state_e           state_reg;
    op_e              op_reg;
    logic [WIDTH-1:0] data_reg;
    logic [3:0]       steps_reg;
    logic             ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             aborted_reg;
    logic             step;

`ifdef SHIFT_CHAIN_STATUS_EN
    logic [15:0]      op_cnt_reg;
    assign op_cnt = op_cnt_reg;
`endif

    // A RUN cycle steps the chain unless abort is sampled on the same edge.
    assign step = (state_reg == ST_RUN) && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_LOAD;
            data_reg    <= '0;
            steps_reg   <= '0;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
`ifdef SHIFT_CHAIN_STATUS_EN
            op_cnt_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_reg    <= op_e'(cmd_op);
                        data_reg  <= cmd_data;
                        steps_reg <= step_total(op_e'(cmd_op), cmd_count);
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_reg   <= ST_DONE;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        aborted_reg <= 1'b1;
                    end else begin
                        steps_reg <= steps_reg - 4'd1;
                        // This edge applies the final step.
                        if (steps_reg == 4'd1) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg   <= ST_IDLE;
                    done_reg    <= 1'b0;
                    aborted_reg <= 1'b0;
                    ready_reg   <= 1'b1;
`ifdef SHIFT_CHAIN_STATUS_EN
                    if (!aborted_reg) begin
                        op_cnt_reg <= op_cnt_reg + 16'd1;
                    end
`endif
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    ready_reg   <= 1'b1;
                    busy_reg    <= 1'b0;
                    done_reg    <= 1'b0;
                    aborted_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign aborted   = aborted_reg;

    shift_chain_regs #(
        .WIDTH (WIDTH)
    ) u_regs (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .op   (op_reg),
        .data (data_reg),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d)
    );

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// tb_shift_chain_ctrl
// Directed bench for shift_chain_ctrl. Each command's expected chain
// contents, aborted flag and RUN length are queued when it is issued and
// compared when done is observed.
module tb_shift_chain_ctrl;
    import shift_chain_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [2:0]   cmd_count;
    logic [W-1:0] cmd_data;
    logic         abort;
    logic [W-1:0] a, b, c, d;
    logic         busy, done, aborted;
`ifdef SHIFT_CHAIN_STATUS_EN
    logic [15:0]  op_cnt;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic         ab;
        int           busy_cyc;
    } exp_t;

    exp_t sb[$];

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [W-1:0] m_a, m_b, m_c, m_d;
    int           m_ops;

    shift_chain_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .abort     (abort),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
`ifdef SHIFT_CHAIN_STATUS_EN
        ,
        .op_cnt    (op_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic [1:0] op, input logic [W-1:0] dat);
        logic [W-1:0] t;
        case (op)
            2'd0: m_a = dat;
            2'd1: begin
                m_d = m_c; m_c = m_b; m_b = m_a; m_a = dat;
            end
            2'd2: begin
                t = m_d; m_d = m_c; m_c = m_b; m_b = m_a; m_a = t;
            end
            default: begin
                m_a = '0; m_b = '0; m_c = '0; m_d = '0;
            end
        endcase
    endtask

    task automatic check_ops(input string tag);
`ifdef SHIFT_CHAIN_STATUS_EN
        check(tag, op_cnt, m_ops[15:0]);
`endif
    endtask

    // abort_at = k raises abort during the k-th RUN cycle (0 = never).
    // hold keeps cmd_valid asserted after acceptance.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt,
                           input logic [W-1:0] dat, input int abort_at, input bit hold);
        exp_t e;
        int   n, steps, k, guard;
        bit   will_abort;
        guard = 0;
        while (!cmd_ready && guard < 20) begin tick(); guard++; end
        check("ready_before_cmd", cmd_ready, 1);
        n = (op == 2'd1 || op == 2'd2) ? ((cnt == 3'd0) ? 8 : int'(cnt)) : 1;
        will_abort = (abort_at > 0) && (abort_at <= n);
        steps = will_abort ? abort_at - 1 : n;
        for (int i = 0; i < steps; i++) model_step(op, dat);
        e.a = m_a; e.b = m_b; e.c = m_c; e.d = m_d;
        e.ab = will_abort;
        e.busy_cyc = will_abort ? abort_at : n;
        if (!will_abort) m_ops++;
        sb.push_back(e);

        cmd_op = op; cmd_count = cnt; cmd_data = dat; cmd_valid = 1'b1;
        tick();
        if (!hold) begin
            // Scramble inputs: they must be ignored once accepted.
            cmd_valid = 1'b0;
            cmd_data  = $urandom;
            cmd_op    = 2'($urandom);
            cmd_count = 3'($urandom);
        end
        k = 0; guard = 0;
        while (!done && guard < 30) begin
            if (busy) k++;
            abort = busy && (k == abort_at);
            tick();
            guard++;
        end
        abort = 1'b0;
        check("done_pulse", done, 1);
        e = sb.pop_front();
        check("a", a, e.a);
        check("b", b, e.b);
        check("c", c, e.c);
        check("d", d, e.d);
        check("aborted", aborted, e.ab);
        check("busy_cycles", k, e.busy_cyc);
        check("ready_in_done", cmd_ready, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("aborted_cleared", aborted, 0);
        check("ready_after_done", cmd_ready, 1);
        check_ops("op_cnt");
        $display("cmd op=%0d cnt=%0d data=%0h abort_at=%0d -> a=%0h b=%0h c=%0h d=%0h busy=%0d",
                 op, cnt, dat, abort_at, a, b, c, d, k);
    endtask

    initial begin
        int guard;
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        cmd_op = '0; cmd_count = '0; cmd_data = '0;
        m_a = '0; m_b = '0; m_c = '0; m_d = '0; m_ops = 0;
        #1;
        check("rst_a", a, 0);
        check("rst_d", d, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check_ops("rst_op_cnt");
        tick(); tick();
        rst = 1'b0;

        // Abort while idle has no effect.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_ready", cmd_ready, 1);

        // LOAD 5 then SHIFT 7 x3.
        run_cmd(2'd0, 3'd0, 32'd5, 0, 0);
        run_cmd(2'd1, 3'd3, 32'd7, 0, 0);
        check("shift3_a", a, 7);
        check("shift3_d", d, 5);

        // Build chain 1,2,3,4 then ROTATE by 8 (count 0).
        run_cmd(2'd0, 3'd0, 32'd4, 0, 0);
        run_cmd(2'd1, 3'd1, 32'd3, 0, 0);
        run_cmd(2'd1, 3'd1, 32'd2, 0, 0);
        run_cmd(2'd1, 3'd1, 32'd1, 0, 0);
        run_cmd(2'd2, 3'd0, 32'd0, 0, 0);
        check("rot8_a", a, 1);
        check("rot8_b", b, 2);
        check("rot8_c", c, 3);
        check("rot8_d", d, 4);

        // ROTATE 5 aborted in the 3rd RUN cycle: two steps.
        run_cmd(2'd2, 3'd5, 32'd0, 3, 0);
        check("rot_abort_a", a, 3);
        check("rot_abort_d", d, 2);

        // CLEAR with cmd_valid held: next command accepted only after DONE.
        run_cmd(2'd3, 3'd0, 32'hFFFF_FFFF, 0, 1);
        check("hold_idle_busy", busy, 0);
        tick();
        check("hold_reaccept_busy", busy, 1);
        cmd_valid = 1'b0;
        m_ops++;
        guard = 0;
        while (!done && guard < 30) begin tick(); guard++; end
        check("hold_second_done", done, 1);
        check("hold_second_a", a, 0);
        tick();
        check_ops("hold_op_cnt");

        // Abort on the edge of the final step suppresses it.
        run_cmd(2'd0, 3'd0, 32'd8, 0, 0);
        run_cmd(2'd1, 3'd2, 32'd9, 2, 0);

        // Reset in the middle of RUN.
        cmd_op = 2'd1; cmd_count = 3'd0; cmd_data = 32'd3; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("midrun_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_a", a, 0);
        check("midrun_rst_b", b, 0);
        check("midrun_rst_ready", cmd_ready, 1);
        check("midrun_rst_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrun_no_done", done, 0);
        end
        rst = 1'b0;
        m_a = '0; m_b = '0; m_c = '0; m_d = '0; m_ops = 0;
        check_ops("midrun_op_cnt");

        // Three completed commands and one aborted.
        run_cmd(2'd0, 3'd0, 32'd1, 0, 0);
        run_cmd(2'd1, 3'd2, 32'd6, 0, 0);
        run_cmd(2'd2, 3'd3, 32'd0, 1, 0);
        run_cmd(2'd3, 3'd0, 32'd0, 0, 0);
`ifdef SHIFT_CHAIN_STATUS_EN
        check("op_cnt_three", op_cnt, 3);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
